// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the 16-bit RISC core.
// Fetches one 16-bit word per request into an instruction register, presents
// opcode to the control unit, and picks the next PC from jump/cmp/alu_zero on accept.
// Optional halt support is enabled by defining IFU_HALT_EN.
module instr_fetch_unit #(
    parameter int unsigned     PC_W        = 12,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_rdata,
    output logic [15:0]     instr,
    output logic [3:0]      opcode,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            jump,
    input  logic            cmp,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StIssue = 2'd2
`ifdef IFU_HALT_EN
        ,
        StHalt  = 2'd3
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [PC_W-1:0]   jump_tgt;
    logic [PC_W-1:0]   br_off;
    logic [PC_W-1:0]   pc_next;
    logic              accept;

    // Redirect targets: absolute jump field and sign-extended branch offset.
    always_comb begin
        jump_tgt = PC_W'(instr_q[11:0]);
        br_off   = PC_W'($signed(instr_q[5:0]));
        if (jump) begin
            pc_next = jump_tgt;
        end else if (cmp && alu_zero) begin
            pc_next = pc_q + PC_W'(1) + br_off;
        end else begin
            pc_next = pc_q + PC_W'(1);
        end
    end

    assign accept = (state_q == StIssue) && instr_ready;

    // Next-state, PC and instruction register update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StReq;
            end
            StReq: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
`ifdef IFU_HALT_EN
                    // The halt instruction ignores jump/cmp and keeps its own pc.
                    if (instr_q[15:12] == HALT_OPCODE) begin
                        state_d = StHalt;
                    end else begin
                        pc_d    = pc_next;
                        state_d = StReq;
                    end
`else
                    pc_d    = pc_next;
                    state_d = StReq;
`endif
                end
            end
`ifdef IFU_HALT_EN
            StHalt: begin
                state_d = StHalt;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with asynchronous reset; outputs decode from it so they drop at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            instr_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[15:12];
    assign instr_valid = (state_q == StIssue);
    assign pc          = pc_q;
`ifdef IFU_HALT_EN
    assign halted      = (state_q == StHalt);
`else
    assign halted      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        jump = 1'b0;
    logic        cmp = 1'b0;
    logic        alu_zero = 1'b0;
    logic [11:0] pc;
    logic        halted;

    int errors = 0;
    int checks = 0;

    instr_fetch_unit #(
        .PC_W       (12),
        .RESET_PC   (12'h000),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .opcode     (opcode),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .jump       (jump),
        .cmp        (cmp),
        .alu_zero   (alu_zero),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expect REQ at addr, ack immediately with word, then expect ISSUE.
    task automatic fetch(input logic [11:0] addr, input logic [15:0] word);
        check("req_high", imem_req, 1'b1);
        check("req_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'hDEAD;
        check("valid", instr_valid, 1'b1);
        check("instr", instr, word);
        check("opcode", opcode, word[15:12]);
        check("pc", pc, addr);
        check("no_req_issue", imem_req, 1'b0);
    endtask

    task automatic accept(input logic j, input logic c, input logic z);
        instr_ready = 1'b1;
        jump        = j;
        cmp         = c;
        alu_zero    = z;
        tick();
        instr_ready = 1'b0;
        jump        = 1'b0;
        cmp         = 1'b0;
        alu_zero    = 1'b0;
        check("valid_drop", instr_valid, 1'b0);
    endtask

    initial begin
        // Reset must act without a clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_pc", pc, 12'h000);
        check("rst_instr", instr, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        // Ack in IDLE is ignored.
        imem_ack = 1'b1;
        imem_rdata = 16'h4444;
        tick();
        imem_ack = 1'b0;
        check("idle_ack_valid", instr_valid, 1'b0);
        check("idle_ack_req", imem_req, 1'b0);
        check("idle_ack_instr", instr, 16'h0000);
        start = 1'b1;
        tick();
        start = 1'b0;

        // T1: sequential fetches with immediate ack.
        fetch(12'h000, 16'h1234);
        accept(1'b0, 1'b0, 1'b0);
        fetch(12'h001, 16'h5678);
        accept(1'b0, 1'b0, 1'b0);
        fetch(12'h002, 16'h9ABC);

        // T2: stall in ISSUE for 5 clocks; start is ignored here.
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            check("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, 16'h9ABC);
            check("stall_opcode", opcode, 4'h9);
            check("stall_pc", pc, 12'h002);
            check("stall_req", imem_req, 1'b0);
        end
        start = 1'b0;
        accept(1'b0, 1'b0, 1'b0);

        // Delayed ack: request and address hold.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("wait_req", imem_req, 1'b1);
            check("wait_addr", imem_addr, 12'h003);
        end

        // T3: jump and cmp together, jump wins.
        fetch(12'h003, 16'h80A5);
        accept(1'b1, 1'b1, 1'b1);
        fetch(12'h0A5, 16'h8010);
        accept(1'b1, 1'b0, 1'b0);

        // T4: backward branch taken, then not taken.
        fetch(12'h010, 16'h003E);
        accept(1'b0, 1'b1, 1'b1);
        fetch(12'h00F, 16'h0010);
        accept(1'b1, 1'b0, 1'b0);
        fetch(12'h010, 16'h003E);
        accept(1'b0, 1'b1, 1'b0);

        // T5: wrap-around.
        fetch(12'h011, 16'h0FFF);
        accept(1'b1, 1'b0, 1'b0);
        fetch(12'hFFF, 16'h1111);
        accept(1'b0, 1'b0, 1'b0);
        fetch(12'h000, 16'h2222);
        accept(1'b0, 1'b0, 1'b0);
        check("wrap_req", imem_req, 1'b1);
        check("wrap_addr", imem_addr, 12'h001);

        // T6: asynchronous reset while a request is outstanding.
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 1'b0);
        check("mid_rst_pc", pc, 12'h000);
        check("mid_rst_instr", instr, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_idle", imem_req, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;

`ifdef IFU_HALT_EN
        fetch(12'h000, 16'hF000);
        accept(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            check("halt_flag", halted, 1'b1);
            check("halt_req", imem_req, 1'b0);
            check("halt_valid", instr_valid, 1'b0);
            tick();
        end
`else
        // 4'hF is an ordinary opcode without halt support.
        fetch(12'h000, 16'hF000);
        accept(1'b0, 1'b0, 1'b0);
        check("nohalt_flag", halted, 1'b0);
        check("nohalt_req", imem_req, 1'b1);
        check("nohalt_addr", imem_addr, 12'h001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
